// File: rtl/line_raster_engine.sv
// Rasteriser front end: buffers draw ops in a small FIFO and walks each one pixel per cycle
// (all-octant Bresenham lines or row-major rect fill). Define LRE_CLIP_EN to drop off-screen pixels.
module line_raster_engine #(
  parameter int CW         = 10,
  parameter int COLW       = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_LOG2  = 2,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*CW+COLW:0]   in_op,
  input  logic                 in_rts,
  output logic                 in_rtr,
  output logic [CW-1:0]        out_x,
  output logic [CW-1:0]        out_y,
  output logic [COLW-1:0]      out_color,
  output logic                 out_last,
  output logic                 out_rts,
  input  logic                 out_rtr,
  output logic                 op_done,
  output logic                 busy
);
  localparam int OPW = 1 + 4*CW + COLW;
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [FIFO_LOG2:0]   CNT_ONE  = 1;
  localparam logic [FIFO_LOG2:0]   CNT_FULL = (FIFO_LOG2+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]        C_ONE    = 1;
  localparam logic signed [CW+1:0] S_ZERO   = '0;

  if (FIFO_DEPTH != (1 << FIFO_LOG2) || SCREEN_W > (1 << CW) || SCREEN_H > (1 << CW)) begin : g_param_check
    $error("line_raster_engine: inconsistent parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN} state_t;
  state_t state_q;

  logic [OPW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [FIFO_LOG2-1:0] wptr_q, rptr_q;
  logic [FIFO_LOG2:0]   cnt_q;
  logic                 push, pop, fifo_empty, emit, step;

  logic [OPW-1:0]       op_q;
  logic                 op_mode;
  logic [CW-1:0]        op_x1, op_y1, op_x2, op_y2;
  logic [COLW-1:0]      op_col;
  logic [CW-1:0]        xmin, xmax, ymin, ymax, start_x, start_y, fin_x, fin_y;
  logic signed [CW+1:0] diff_x, diff_y, abs_x, abs_y;

  logic signed [CW+1:0] dx_q, dy_q, err_q, err_n;
  logic signed [CW+2:0] e2, dx_e, dy_e;
  logic                 sx_q, sy_q, step_x, step_y;
  logic [CW-1:0]        end_x_q, end_y_q, wrap_x_q, nx, ny;

  logic [CW-1:0]        cur_x_q, cur_y_q;
  logic [COLW-1:0]      color_q;
  logic                 vld_q, last_q;

  assign fifo_empty = (cnt_q == '0);
  assign in_rtr     = (cnt_q != CNT_FULL);
  assign push       = in_rts && in_rtr;
  // Pop either from IDLE or directly on the final transfer, leaving one bubble between ops.
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || (step && last_q));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= in_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign op_mode = op_q[OPW-1];
  assign op_x1   = op_q[OPW-2 -: CW];
  assign op_y1   = op_q[OPW-2-CW -: CW];
  assign op_x2   = op_q[OPW-2-2*CW -: CW];
  assign op_y2   = op_q[OPW-2-3*CW -: CW];
  assign op_col  = op_q[COLW-1:0];

  // Setup: widened signed deltas so no endpoint difference can wrap.
  assign diff_x  = $signed({2'b00, op_x2}) - $signed({2'b00, op_x1});
  assign diff_y  = $signed({2'b00, op_y2}) - $signed({2'b00, op_y1});
  assign abs_x   = diff_x[CW+1] ? -diff_x : diff_x;
  assign abs_y   = diff_y[CW+1] ? -diff_y : diff_y;
  assign xmin    = (op_x1 < op_x2) ? op_x1 : op_x2;
  assign xmax    = (op_x1 < op_x2) ? op_x2 : op_x1;
  assign ymin    = (op_y1 < op_y2) ? op_y1 : op_y2;
  assign ymax    = (op_y1 < op_y2) ? op_y2 : op_y1;
  assign start_x = op_mode ? xmin : op_x1;
  assign start_y = op_mode ? ymin : op_y1;
  assign fin_x   = op_mode ? xmax : op_x2;
  assign fin_y   = op_mode ? ymax : op_y2;

  assign e2     = $signed({err_q, 1'b0});
  assign dx_e   = $signed({dx_q[CW+1], dx_q});
  assign dy_e   = $signed({dy_q[CW+1], dy_q});
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign err_n  = err_q + (step_x ? dy_q : S_ZERO) + (step_y ? dx_q : S_ZERO);

  always_comb begin
    nx = cur_x_q;
    ny = cur_y_q;
    if (op_mode) begin
      if (cur_x_q == end_x_q) begin
        nx = wrap_x_q;
        ny = cur_y_q + C_ONE;
      end else begin
        nx = cur_x_q + C_ONE;
      end
    end else begin
      if (step_x) nx = sx_q ? cur_x_q + C_ONE : cur_x_q - C_ONE;
      if (step_y) ny = sy_q ? cur_y_q + C_ONE : cur_y_q - C_ONE;
    end
  end

`ifdef LRE_CLIP_EN
  localparam logic [CW:0] SCR_W = (CW+1)'(SCREEN_W);
  localparam logic [CW:0] SCR_H = (CW+1)'(SCREEN_H);
  assign emit = ({1'b0, cur_x_q} < SCR_W) && ({1'b0, cur_y_q} < SCR_H);
`else
  assign emit = 1'b1;
`endif

  // Suppressed pixels advance without waiting on downstream.
  assign step      = (state_q == S_RUN) && vld_q && (out_rtr || !emit);
  assign out_rts   = vld_q && emit;
  assign out_last  = vld_q && last_q && emit;
  assign op_done   = step && last_q && !rst;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign out_x     = cur_x_q;
  assign out_y     = cur_y_q;
  assign out_color = color_q;

  always_ff @(posedge clk) begin
    if (pop) op_q <= fifo_mem[rptr_q];
    if (state_q == S_SETUP) begin
      dx_q     <= abs_x;
      dy_q     <= -abs_y;
      err_q    <= abs_x - abs_y;
      sx_q     <= ~diff_x[CW+1];
      sy_q     <= ~diff_y[CW+1];
      end_x_q  <= fin_x;
      end_y_q  <= fin_y;
      wrap_x_q <= xmin;
    end else if (step) begin
      err_q <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      color_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) state_q <= S_SETUP;
        S_SETUP: begin
          cur_x_q <= start_x;
          cur_y_q <= start_y;
          color_q <= op_col;
          last_q  <= (start_x == fin_x) && (start_y == fin_y);
          vld_q   <= 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: if (step) begin
          if (last_q) begin
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            state_q <= fifo_empty ? S_IDLE : S_SETUP;
          end else begin
            cur_x_q <= nx;
            cur_y_q <= ny;
            last_q  <= (nx == end_x_q) && (ny == end_y_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine: table of ops with hand-walked pixel lists,
// plus sequences for latency, back-pressure, FIFO fill/drain and mid-op reset.
module tb_line_raster_engine;
  localparam int CW = 10, COLW = 12, OPW = 1 + 4*CW + COLW, NV = 9;

  logic            clk = 1'b0, rst, in_rts, in_rtr, out_last, out_rts, out_rtr, op_done, busy;
  logic [OPW-1:0]  in_op;
  logic [CW-1:0]   out_x, out_y;
  logic [COLW-1:0] out_color;

  line_raster_engine dut (
    .clk(clk), .rst(rst), .in_op(in_op), .in_rts(in_rts), .in_rtr(in_rtr),
    .out_x(out_x), .out_y(out_y), .out_color(out_color), .out_last(out_last),
    .out_rts(out_rts), .out_rtr(out_rtr), .op_done(op_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int px_q[$], py_q[$], pc_q[$], pl_q[$];
  int done_cnt = 0;
  bit done_last, done_busy;
  int errors = 0, checks = 0;

  always @(negedge clk) begin
    if (out_rts && out_rtr) begin
      px_q.push_back(int'(out_x));
      py_q.push_back(int'(out_y));
      pc_q.push_back(int'(out_color));
      pl_q.push_back(int'(out_last));
    end
    if (op_done) begin
      done_cnt++;
      done_last = out_rts && out_last && out_rtr;
      done_busy = busy;
    end
  end

  typedef struct {
    logic mode;
    int x1, y1, x2, y2, col, n, last_exp;
    int px[8];
    int py[8];
  } vec_t;
  vec_t v[NV];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [OPW-1:0] mk(input logic m, input int x1, input int y1,
                                        input int x2, input int y2, input int c);
    return {m, x1[CW-1:0], y1[CW-1:0], x2[CW-1:0], y2[CW-1:0], c[COLW-1:0]};
  endfunction

  task automatic push_op(input logic m, input int x1, input int y1, input int x2, input int y2, input int c);
    int t = 0;
    in_op  = mk(m, x1, y1, x2, y2, c);
    in_rts = 1'b1;
    while (!in_rtr && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_rtr) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_rts = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_done", (done_cnt >= target) ? 1 : 0, 1);
  endtask

  initial begin
    int base, d0, acc;
    bit ok;

    v[0].mode = 0; v[0].x1 = 0; v[0].y1 = 0; v[0].x2 = 3; v[0].y2 = 1; v[0].col = 'hABC; v[0].n = 4; v[0].last_exp = 1;
    v[0].px = '{0, 1, 2, 3, 0, 0, 0, 0}; v[0].py = '{0, 0, 1, 1, 0, 0, 0, 0};
    v[1].mode = 0; v[1].x1 = 5; v[1].y1 = 5; v[1].x2 = 5; v[1].y2 = 2; v[1].col = 'h111; v[1].n = 4; v[1].last_exp = 1;
    v[1].px = '{5, 5, 5, 5, 0, 0, 0, 0}; v[1].py = '{5, 4, 3, 2, 0, 0, 0, 0};
    v[2].mode = 0; v[2].x1 = 3; v[2].y1 = 3; v[2].x2 = 0; v[2].y2 = 0; v[2].col = 'h222; v[2].n = 4; v[2].last_exp = 1;
    v[2].px = '{3, 2, 1, 0, 0, 0, 0, 0}; v[2].py = '{3, 2, 1, 0, 0, 0, 0, 0};
    v[3].mode = 1; v[3].x1 = 2; v[3].y1 = 3; v[3].x2 = 1; v[3].y2 = 2; v[3].col = 'h5A5; v[3].n = 4; v[3].last_exp = 1;
    v[3].px = '{1, 2, 1, 2, 0, 0, 0, 0}; v[3].py = '{2, 2, 3, 3, 0, 0, 0, 0};
    v[4].mode = 0; v[4].x1 = 9; v[4].y1 = 9; v[4].x2 = 9; v[4].y2 = 9; v[4].col = 'h333; v[4].n = 1; v[4].last_exp = 1;
    v[4].px = '{9, 0, 0, 0, 0, 0, 0, 0}; v[4].py = '{9, 0, 0, 0, 0, 0, 0, 0};
    v[5].mode = 0; v[5].x1 = 0; v[5].y1 = 0; v[5].x2 = 1; v[5].y2 = 3; v[5].col = 'h444; v[5].n = 4; v[5].last_exp = 1;
    v[5].px = '{0, 0, 1, 1, 0, 0, 0, 0}; v[5].py = '{0, 1, 2, 3, 0, 0, 0, 0};
    v[6].mode = 1; v[6].x1 = 4; v[6].y1 = 1; v[6].x2 = 6; v[6].y2 = 2; v[6].col = 'h555; v[6].n = 6; v[6].last_exp = 1;
    v[6].px = '{4, 5, 6, 4, 5, 6, 0, 0}; v[6].py = '{1, 1, 1, 2, 2, 2, 0, 0};
    v[7].mode = 1; v[7].x1 = 3; v[7].y1 = 7; v[7].x2 = 0; v[7].y2 = 7; v[7].col = 'h666; v[7].n = 4; v[7].last_exp = 1;
    v[7].px = '{0, 1, 2, 3, 0, 0, 0, 0}; v[7].py = '{7, 7, 7, 7, 0, 0, 0, 0};
    v[8].mode = 0; v[8].x1 = 638; v[8].y1 = 0; v[8].x2 = 641; v[8].y2 = 0; v[8].col = 'h777;
`ifdef LRE_CLIP_EN
    v[8].n = 2; v[8].last_exp = 0;
    v[8].px = '{638, 639, 0, 0, 0, 0, 0, 0};
`else
    v[8].n = 4; v[8].last_exp = 1;
    v[8].px = '{638, 639, 640, 641, 0, 0, 0, 0};
`endif
    v[8].py = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; in_rts = 1'b0; out_rtr = 1'b1; in_op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_rts", int'(out_rts), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_op_done", int'(op_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_color", int'(out_color), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_rtr", int'(in_rtr), 1);

    // Latency: push, pop, SETUP, then first pixel valid.
    push_op(0, 7, 5, 7, 5, 'h123);
    chk("lat_c0_rts", int'(out_rts), 0);
    @(posedge clk); #1;
    chk("lat_c1_rts", int'(out_rts), 0);
    chk("lat_c1_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("lat_c2_rts", int'(out_rts), 1);
    chk("lat_c2_x", int'(out_x), 7);
    chk("lat_c2_y", int'(out_y), 5);
    chk("lat_c2_col", int'(out_color), 'h123);
    chk("lat_c2_last", int'(out_last), 1);
    chk("lat_c2_done", int'(op_done), 1);
    @(posedge clk); #1;
    chk("lat_c3_rts", int'(out_rts), 0);
    chk("lat_c3_busy", int'(busy), 0);

    for (int i = 0; i < NV; i++) begin
      base = px_q.size();
      d0 = done_cnt;
      push_op(v[i].mode, v[i].x1, v[i].y1, v[i].x2, v[i].y2, v[i].col);
      wait_done(d0 + 1, 200);
      chk($sformatf("vec%0d_count", i), px_q.size() - base, v[i].n);
      chk($sformatf("vec%0d_done_on_last", i), int'(done_last), v[i].last_exp);
      for (int j = 0; j < v[i].n; j++) begin
        if (base + j >= px_q.size()) break;
        chk($sformatf("vec%0d_x%0d", i, j), px_q[base+j], v[i].px[j]);
        chk($sformatf("vec%0d_y%0d", i, j), py_q[base+j], v[i].py[j]);
        chk($sformatf("vec%0d_col%0d", i, j), pc_q[base+j], v[i].col);
        chk($sformatf("vec%0d_last%0d", i, j), pl_q[base+j], ((j == v[i].n - 1) && v[i].last_exp) ? 1 : 0);
      end
      @(posedge clk); #1;
    end

    // Back-pressure: hold the second pixel for three cycles.
    base = px_q.size();
    d0 = done_cnt;
    push_op(0, 0, 0, 7, 0, 'h0F0);
    for (int t = 0; t < 20 && !out_rts; t++) begin
      @(posedge clk); #1;
    end
    chk("stall_first_x", int'(out_x), 0);
    @(posedge clk); #1;
    out_rtr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_hold_rts%0d", k), int'(out_rts), 1);
      chk($sformatf("stall_hold_x%0d", k), int'(out_x), 1);
      chk($sformatf("stall_hold_y%0d", k), int'(out_y), 0);
      @(posedge clk); #1;
    end
    out_rtr = 1'b1;
    wait_done(d0 + 1, 100);
    chk("stall_count", px_q.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      if (base + k >= px_q.size()) break;
      chk($sformatf("stall_x%0d", k), px_q[base+k], k);
    end
    @(posedge clk); #1;

    // FIFO fill with downstream blocked: walker holds one op, FIFO four more.
    out_rtr = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_op  = mk(0, 0, acc, 1, acc, 'h100 + acc);
      in_rts = 1'b1;
      ok = in_rtr;
      @(posedge clk); #1;
      if (ok) acc++;
    end
    in_rts = 1'b0;
    chk("fill_accepted", acc, 5);
    chk("fill_in_rtr", int'(in_rtr), 0);
    chk("fill_busy", int'(busy), 1);
    chk("fill_head_col", int'(out_color), 'h100);
    base = px_q.size();
    d0 = done_cnt;
    out_rtr = 1'b1;
    wait_done(d0 + 5, 200);
    chk("drain_count", px_q.size() - base, 10);
    for (int k = 0; k < 5; k++) begin
      if (base + 2*k + 1 >= px_q.size()) break;
      chk($sformatf("drain_col%0d", k), pc_q[base+2*k], 'h100 + k);
      chk($sformatf("drain_y%0d", k), py_q[base+2*k+1], k);
      chk($sformatf("drain_x%0d", k), px_q[base+2*k+1], 1);
    end
    chk("drain_busy_at_done", int'(done_busy), 1);
    @(posedge clk); #1;
    chk("drain_busy_after", int'(busy), 0);

    // Reset in the middle of a line with ops still queued.
    out_rtr = 1'b0;
    push_op(0, 0, 0, 20, 0, 'h00A);
    push_op(0, 0, 1, 5, 1, 'h00B);
    push_op(0, 0, 2, 5, 2, 'h00C);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_pre_rts", int'(out_rts), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_rts", int'(out_rts), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_rtr", int'(in_rtr), 1);
    chk("midrst_last", int'(out_last), 0);
    base = px_q.size();
    out_rtr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_pixels", px_q.size() - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
